seq_divider: RTL

- Iterative unsigned integer divider; the inverse-operation companion to the ripple add/subtract datapath.
- Computes quotient and remainder of an n-bit dividend by an n-bit divisor using restoring shift-subtract, one quotient bit per clock.
- Sits beside the combinational ALU as a multicycle functional unit, driven by a start/busy/done handshake from the controlling sequencer.

---
 rtl/seq_divider.sv | 107 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Iterative unsigned divider, restoring shift-subtract, one
//            quotient bit per clock with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         divbyzero
);

    localparam int                 c_cnt_w = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_count;
    logic [N-1:0]       r_rem;
    logic [N-1:0]       r_q;
    logic [N-1:0]       r_div;

    logic [N:0]         w_shifted;
    logic [N:0]         w_trial;
    logic               w_fits;
    logic [N-1:0]       w_rem_next;
    logic [N-1:0]       w_q_next;

    // Partial remainder stays below the divisor, so the shifted value is
    // below 2*divisor and bit N of the n+1-bit difference is its sign.
    assign w_shifted  = {r_rem, r_q[N-1]};
    assign w_trial    = w_shifted - {1'b0, r_div};
    assign w_fits     = ~w_trial[N];
    assign w_rem_next = w_fits ? w_trial[N-1:0] : w_shifted[N-1:0];
    assign w_q_next   = {r_q[N-2:0], w_fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_div     <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divbyzero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last) begin
                        quotient  <= w_q_next;
                        remainder <= w_rem_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_FIN;
                    end
                end
                default: begin
                    // IDLE and FIN both accept, giving back-to-back issue.
                    if (start) begin
                        r_div <= divisor;
                        if (divisor != '0) begin
                            divbyzero <= 1'b0;
                            r_state   <= S_RUN;
                            r_count   <= '0;
                            r_rem     <= '0;
                            r_q       <= dividend;
                            busy      <= 1'b1;
                        end else begin
                            divbyzero <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                            done      <= 1'b1;
                            r_state   <= S_FIN;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
